// File: rtl/reset_sequencer.sv
// Staged reset release: holds every downstream domain in reset, then frees them
// one at a time in index order, waiting for each stage's init ack plus a gap.
module reset_sequencer #(
  parameter int STAGES      = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 8,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_swRst,
  input  logic [STAGES-1:0] i_stageAck,
  output logic [STAGES-1:0] o_stageRst,
  output logic [3:0]        o_curStage,
  output logic              o_seqDone,
  output logic              o_timeoutErr
);

  localparam int MAXC_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAXC    = (MAXC_HG > ACK_TIMEOUT) ? MAXC_HG : ACK_TIMEOUT;
  localparam int CW      = (MAXC > 1) ? $clog2(MAXC + 1) : 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] ACK_LAST  = (ACK_TIMEOUT == 0) ? '0 : CW'(ACK_TIMEOUT - 1);
  localparam logic [3:0]    LAST_IDX  = 4'(STAGES - 1);
  localparam logic          NO_WAIT   = (ACK_TIMEOUT == 0);

  localparam logic [1:0] S_HOLD = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_RUN  = 2'd3;

  logic [1:0]        r_state;
  logic [CW-1:0]     r_cnt;
  logic [3:0]        r_cur;
  logic [STAGES-1:0] r_stageRst;
  logic              r_seqDone;
  logic              r_timeoutErr;

  logic              w_ack;
  logic [3:0]        w_nxtCur;
  logic [STAGES-1:0] w_nxtMask;
  logic              w_ackOk;
  logic              w_waitExit;
  logic              w_isLast;

  // Only the stage currently being waited on has its ack looked at.
  always_comb begin
    w_ack     = 1'b0;
    w_nxtMask = '0;
    w_nxtCur  = r_cur + 4'd1;
    for (int i = 0; i < STAGES; i++) begin
      if (r_cur == 4'(i))    w_ack        = i_stageAck[i];
      if (w_nxtCur == 4'(i)) w_nxtMask[i] = 1'b1;
    end
  end

  assign w_ackOk    = w_ack | NO_WAIT;
  assign w_waitExit = w_ackOk | (r_cnt == ACK_LAST);
  assign w_isLast   = (r_cur == LAST_IDX);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_HOLD;
      r_cnt        <= '0;
      r_cur        <= '0;
      r_stageRst   <= '1;
      r_seqDone    <= 1'b0;
      r_timeoutErr <= 1'b0;
    end else if (i_swRst) begin
      // Software restart keeps the sticky timeout flag for post-mortem.
      r_state    <= S_HOLD;
      r_cnt      <= '0;
      r_cur      <= '0;
      r_stageRst <= '1;
      r_seqDone  <= 1'b0;
    end else begin
      case (r_state)
        S_HOLD: begin
          if (r_cnt == HOLD_LAST) begin
            r_stageRst[0] <= 1'b0;
            r_cnt         <= '0;
            r_state       <= S_WAIT;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_WAIT: begin
          if (w_waitExit) begin
            if (!w_ackOk) r_timeoutErr <= 1'b1;
            r_cnt <= '0;
            if (w_isLast) begin
              r_state   <= S_RUN;
              r_seqDone <= 1'b1;
            end else begin
              r_state <= S_GAP;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_cur      <= w_nxtCur;
            r_stageRst <= r_stageRst & ~w_nxtMask;
            r_cnt      <= '0;
            r_state    <= S_WAIT;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_stageRst   = r_stageRst;
  assign o_curStage   = r_cur;
  assign o_seqDone    = r_seqDone;
  assign o_timeoutErr = r_timeoutErr;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: event-time model checked every cycle on two
// instances (default timeout and no-ack-wait), plus directed literal checks.
module tb_reset_sequencer;
  localparam int S = 4, HOLD = 16, GAP = 8, TO = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, swRst, swRst1;
  logic [S-1:0] ack, ack1;
  logic [S-1:0] srst0, srst1;
  logic [3:0]   cur0, cur1;
  logic         done0, done1, err0, err1;

  reset_sequencer #(.STAGES(S), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .ACK_TIMEOUT(TO)) u0 (
    .i_clk(clk), .i_rst(rst), .i_swRst(swRst), .i_stageAck(ack),
    .o_stageRst(srst0), .o_curStage(cur0), .o_seqDone(done0), .o_timeoutErr(err0));

  reset_sequencer #(.STAGES(S), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .ACK_TIMEOUT(0)) u1 (
    .i_clk(clk), .i_rst(rst), .i_swRst(swRst1), .i_stageAck(ack1),
    .o_stageRst(srst1), .o_curStage(cur1), .o_seqDone(done1), .o_timeoutErr(err1));

  int vec = 0, miss = 0, cyc = 0, ed = 0;

  // Model in absolute edge numbers: n counts clean edges since the last reset.
  typedef struct {
    logic [S-1:0] srst;
    logic         done, err;
    int           cur, n, rel, wstart, nextRel;
    bit           waiting;
  } mdl_t;
  mdl_t m0, m1;

  function automatic void mrelease(inout mdl_t m, input int k);
    m.srst[k] = 1'b0;
    m.rel     = k + 1;
    m.cur     = k;
    m.waiting = 1'b1;
    m.wstart  = m.n;
  endfunction

  function automatic void mstep(inout mdl_t m, input int tmo, input logic r, input logic sw,
                                input logic [S-1:0] a);
    bit acked, tout;
    if (r || sw) begin
      m.srst = '1; m.done = 1'b0; m.cur = 0; m.n = 0; m.rel = 0;
      m.waiting = 1'b0; m.nextRel = 0; m.wstart = 0;
      if (r) m.err = 1'b0;
    end else begin
      m.n++;
      if (m.rel == 0) begin
        if (m.n == HOLD) mrelease(m, 0);
      end else if (m.waiting) begin
        acked = (tmo == 0) || (a[m.rel-1] == 1'b1);
        tout  = !acked && (m.n - m.wstart == tmo);
        if (acked || tout) begin
          m.waiting = 1'b0;
          if (tout) m.err = 1'b1;
          if (m.rel == S) m.done = 1'b1;
          else m.nextRel = m.n + GAP;
        end
      end else if (m.rel < S && m.n == m.nextRel) begin
        mrelease(m, m.rel);
      end
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    mstep(m0, TO, rst, swRst, ack);
    mstep(m1, 0, rst, swRst1, ack1);
    cyc++;
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("u0.stageRst", 32'(srst0), 32'(m0.srst));
      chk("u0.curStage", 32'(cur0), 32'(m0.cur));
      chk("u0.seqDone", 32'(done0), 32'(m0.done));
      chk("u0.timeoutErr", 32'(err0), 32'(m0.err));
      chk("u1.stageRst", 32'(srst1), 32'(m1.srst));
      chk("u1.curStage", 32'(cur1), 32'(m1.cur));
      chk("u1.seqDone", 32'(done1), 32'(m1.done));
      chk("u1.timeoutErr", 32'(err1), 32'(m1.err));
    end
  end

  task automatic to_edge(input int k);
    while (ed < k) begin
      @(posedge clk);
      ed++;
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; swRst = 1'b0; swRst1 = 1'b0; ack = '1; ack1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst srst0", 32'(srst0), 32'hF);
    chk("rst done0", 32'(done0), 32'h0);
    chk("rst err0", 32'(err0), 32'h0);
    chk("rst cur0", 32'(cur0), 32'h0);
    chk("rst srst1", 32'(srst1), 32'hF);

    // all stages ack immediately
    @(negedge clk); rst = 1'b0; ed = 0;
    to_edge(15); chk("t1 srst@15", 32'(srst0), 32'hF);
    to_edge(16); chk("t1 srst@16", 32'(srst0), 32'hE); chk("t6 srst@16", 32'(srst1), 32'hE);
    to_edge(25); chk("t1 srst@25", 32'(srst0), 32'hC); chk("t1 cur@25", 32'(cur0), 32'd1);
    to_edge(34); chk("t1 srst@34", 32'(srst0), 32'h8); chk("t1 cur@34", 32'(cur0), 32'd2);
    to_edge(43); chk("t1 srst@43", 32'(srst0), 32'h0); chk("t1 done@43", 32'(done0), 32'h0);
    chk("t1 cur@43", 32'(cur0), 32'd3); chk("t6 srst@43", 32'(srst1), 32'h0);
    to_edge(44); chk("t1 done@44", 32'(done0), 32'h1); chk("t1 err@44", 32'(err0), 32'h0);
    chk("t6 done@44", 32'(done1), 32'h1); chk("t6 err@44", 32'(err1), 32'h0);

    // stage 1 never acks
    @(negedge clk); rst = 1'b1; ack = 4'b1101;
    @(negedge clk); rst = 1'b0; ed = 0;
    to_edge(25);  chk("t2 srst@25", 32'(srst0), 32'hC);
    to_edge(279); chk("t2 err@279", 32'(err0), 32'h0);
    to_edge(280); chk("t2 err@280", 32'(err0), 32'h1);
    to_edge(287); chk("t2 srst@287", 32'(srst0), 32'hC);
    to_edge(288); chk("t2 srst@288", 32'(srst0), 32'h8);
    to_edge(297); chk("t2 srst@297", 32'(srst0), 32'h0); chk("t2 done@297", 32'(done0), 32'h0);
    to_edge(298); chk("t2 done@298", 32'(done0), 32'h1);

    // software restart from RUN keeps timeoutErr
    @(negedge clk); swRst = 1'b1;
    @(posedge clk); #1;
    chk("t3 srst", 32'(srst0), 32'hF); chk("t3 done", 32'(done0), 32'h0);
    chk("t3 cur", 32'(cur0), 32'h0);   chk("t3 err", 32'(err0), 32'h1);
    @(negedge clk); swRst = 1'b0; ack = 4'b0011; ed = 0;
    to_edge(15); chk("t3 srst@15", 32'(srst0), 32'hF);
    to_edge(16); chk("t3 srst@16", 32'(srst0), 32'hE); chk("t3 err@16", 32'(err0), 32'h1);
    to_edge(34); chk("t3 srst@34", 32'(srst0), 32'h8); chk("t3 cur@34", 32'(cur0), 32'd2);
    to_edge(40); chk("t4 pre srst", 32'(srst0), 32'h8);

    // hard reset while waiting on stage 2
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("t4 srst", 32'(srst0), 32'hF); chk("t4 done", 32'(done0), 32'h0);
    chk("t4 err", 32'(err0), 32'h0);   chk("t4 cur", 32'(cur0), 32'h0);

    // rst and swRst overlap, swRst held past rst
    @(negedge clk); swRst = 1'b1;
    @(posedge clk);
    @(negedge clk); rst = 1'b0; ack = '1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("t5 srst hold", 32'(srst0), 32'hF);
      chk("t5 done hold", 32'(done0), 32'h0);
    end
    @(negedge clk); swRst = 1'b0; ed = 0;
    to_edge(15); chk("t5 srst@15", 32'(srst0), 32'hF);
    to_edge(16); chk("t5 srst@16", 32'(srst0), 32'hE);
    to_edge(44); chk("t5 done@44", 32'(done0), 32'h1);

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
